// File: rtl/mem_arbiter2.sv
// mem_arbiter2: two-master round-robin arbiter in front of one picorv32-native
// memory port, with a watchdog that force-completes hung transfers.
//
// Ports:
//   clk, resetn                  clock / asynchronous active-low reset
//   m0_* / m1_*                  master ports (valid, ready, addr, wdata, wstrb, rdata)
//   s_*                          shared slave port (valid, ready, addr, wdata, wstrb, rdata)
//   timeout_err                  sticky watchdog-expiry flag, cleared only by reset
//   err_addr                     s_addr of the most recent timed-out transfer
//
// Parameters:
//   TIMEOUT    BUSY cycles without s_ready before forced completion (0 disables)
//   ERR_RDATA  read data returned to the master on a timed-out transfer
module mem_arbiter2 #(
  parameter logic [15:0] TIMEOUT   = 16'd1024,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        timeout_err,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  state_t      state, state_d;
  logic        last_grant, last_grant_d;
  logic [15:0] wdog, wdog_d;
  logic        err_set;

  // Granted-master view: selected by registered state only, so the slave
  // side never sees a combinational path from the master valids.
  logic        busy, sel;
  logic        g_valid;
  logic        g_ready;
  logic [31:0] g_rdata;
  logic        expire;

  assign busy    = (state != IDLE);
  assign sel     = (state == BUSY1);
  assign g_valid = sel ? m1_valid : m0_valid;
  assign expire  = (TIMEOUT != 16'd0) && (wdog == TIMEOUT - 16'd1) && !s_ready;

  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    wdog_d       = wdog;
    err_set      = 1'b0;
    g_ready      = 1'b0;
    g_rdata      = '0;
    s_valid      = busy;
    s_addr       = '0;
    s_wdata      = '0;
    s_wstrb      = '0;
    m0_ready     = 1'b0;
    m0_rdata     = '0;
    m1_ready     = 1'b0;
    m1_rdata     = '0;

    if (busy) begin
      s_addr  = sel ? m1_addr  : m0_addr;
      s_wdata = sel ? m1_wdata : m0_wdata;
      s_wstrb = sel ? m1_wstrb : m0_wstrb;
    end

    case (state)
      IDLE: begin
        wdog_d = '0;
        // Tie goes to the master that was not served last.
        if (m0_valid && (!m1_valid || last_grant)) state_d = BUSY0;
        else if (m1_valid)                         state_d = BUSY1;
      end
      BUSY0, BUSY1: begin
        if (!g_valid) begin
          // Requester withdrew: abandon quietly, fairness history untouched.
          state_d = IDLE;
          wdog_d  = '0;
        end else if (s_ready) begin
          g_ready      = 1'b1;
          g_rdata      = s_rdata;
          state_d      = IDLE;
          last_grant_d = sel;
          wdog_d       = '0;
        end else if (expire) begin
          g_ready      = 1'b1;
          g_rdata      = ERR_RDATA;
          state_d      = IDLE;
          last_grant_d = sel;
          wdog_d       = '0;
          err_set      = 1'b1;
        end else begin
          g_rdata = s_rdata;
          if (wdog != 16'hFFFF) wdog_d = wdog + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        wdog_d  = '0;
      end
    endcase

    if (busy && !sel) begin
      m0_ready = g_ready;
      m0_rdata = g_rdata;
    end
    if (sel) begin
      m1_ready = g_ready;
      m1_rdata = g_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      wdog        <= '0;
      timeout_err <= 1'b0;
      err_addr    <= '0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      wdog       <= wdog_d;
      if (err_set) begin
        timeout_err <= 1'b1;
        err_addr    <= s_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter2.sv
module tb_mem_arbiter2;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        m0_valid, m0_ready, m1_valid, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic        s_valid, s_ready, timeout_err;
  logic [31:0] s_addr, s_wdata, s_rdata, err_addr;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter2 #(.TIMEOUT(16'd8), .ERR_RDATA(32'hDEADBEEF)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .timeout_err(timeout_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 1 unit later, well away from the next edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m0_valid = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready  = 0; s_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    #3;
    n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL reset_s_valid got %b want 0", s_valid); end
    n_cmp++; if ({m0_ready, m1_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready got %b want 00", {m0_ready, m1_ready}); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
    n_cmp++; if (err_addr !== 32'h0) begin n_bad++; $display("FAIL reset_err_addr got %h want 0", err_addr); end
    next_cycle();
    next_cycle();
    resetn = 1'b1;
    settle();
  endtask

  task automatic test_m0_read();
    next_cycle();
    m0_valid = 1; m0_addr = 32'h0001_0000; m0_wstrb = 4'h0; m0_wdata = '0;
    settle();
    n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL rd_arb_cycle s_valid got %b want 0", s_valid); end
    next_cycle(); settle();
    n_cmp++; if ({s_valid, s_addr, s_wstrb} !== {1'b1, 32'h0001_0000, 4'h0}) begin n_bad++; $display("FAIL rd_slave_req got %b/%h/%h want 1/00010000/0", s_valid, s_addr, s_wstrb); end
    n_cmp++; if (m0_ready !== 1'b0) begin n_bad++; $display("FAIL rd_early_ready got %b want 0", m0_ready); end
    next_cycle();
    s_ready = 1; s_rdata = 32'h1234_5678;
    settle();
    n_cmp++; if ({m0_ready, m0_rdata} !== {1'b1, 32'h1234_5678}) begin n_bad++; $display("FAIL rd_done got %b/%h want 1/12345678", m0_ready, m0_rdata); end
    n_cmp++; if (m1_ready !== 1'b0) begin n_bad++; $display("FAIL rd_m1_ready got %b want 0", m1_ready); end
    next_cycle();
    m0_valid = 0; s_ready = 0;
    settle();
    n_cmp++; if ({s_valid, m0_ready} !== 2'b00) begin n_bad++; $display("FAIL rd_after got %b want 00", {s_valid, m0_ready}); end
  endtask

  task automatic test_m1_write();
    next_cycle();
    m1_valid = 1; m1_addr = 32'h1000_0000; m1_wdata = 32'h41; m1_wstrb = 4'hF;
    s_ready = 1; s_rdata = 32'h5555_AAAA;
    settle();
    n_cmp++; if ({s_valid, m1_ready} !== 2'b00) begin n_bad++; $display("FAIL wr_arb_cycle got %b want 00", {s_valid, m1_ready}); end
    next_cycle(); settle();
    n_cmp++; if ({s_valid, s_addr, s_wdata, s_wstrb} !== {1'b1, 32'h1000_0000, 32'h41, 4'hF}) begin n_bad++; $display("FAIL wr_slave_req got %b/%h/%h/%h want 1/10000000/00000041/f", s_valid, s_addr, s_wdata, s_wstrb); end
    n_cmp++; if ({m0_ready, m1_ready} !== 2'b01) begin n_bad++; $display("FAIL wr_ready got %b want 01", {m0_ready, m1_ready}); end
    next_cycle();
    m1_valid = 0; s_ready = 0;
    settle();
    n_cmp++; if ({s_valid, m1_ready} !== 2'b00) begin n_bad++; $display("FAIL wr_single_pulse got %b want 00", {s_valid, m1_ready}); end
  endtask

  task automatic test_timeout();
    next_cycle();
    m0_valid = 1; m0_addr = 32'h20; m0_wstrb = 4'h0; s_ready = 0; s_rdata = 32'h0BAD_0BAD;
    settle();
    for (int c = 1; c <= 8; c++) begin
      next_cycle(); settle();
      if (c < 8) begin
        n_cmp++; if ({s_valid, m0_ready} !== 2'b10) begin n_bad++; $display("FAIL to_wait cycle %0d got %b want 10", c, {s_valid, m0_ready}); end
      end else begin
        n_cmp++; if ({s_valid, m0_ready, m0_rdata} !== {2'b11, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL to_expire got %b/%b/%h want 1/1/deadbeef", s_valid, m0_ready, m0_rdata); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_err_early got %b want 0", timeout_err); end
      end
    end
    next_cycle();
    m0_valid = 0;
    settle();
    n_cmp++; if ({timeout_err, err_addr} !== {1'b1, 32'h20}) begin n_bad++; $display("FAIL to_err_flag got %b/%h want 1/00000020", timeout_err, err_addr); end
    n_cmp++; if ({s_valid, m0_ready} !== 2'b00) begin n_bad++; $display("FAIL to_after got %b want 00", {s_valid, m0_ready}); end
  endtask

  task automatic test_late_ready();
    test_reset();
    next_cycle();
    m1_valid = 1; m1_addr = 32'h44; m1_wstrb = 4'h0;
    settle();
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      s_ready = (c == 8); s_rdata = 32'hCAFE_F00D;
      settle();
      if (c == 8) begin
        n_cmp++; if ({m1_ready, m1_rdata} !== {1'b1, 32'hCAFE_F00D}) begin n_bad++; $display("FAIL late_done got %b/%h want 1/cafef00d", m1_ready, m1_rdata); end
      end
    end
    next_cycle();
    m1_valid = 0; s_ready = 0;
    settle();
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL late_no_err got %b want 0", timeout_err); end
  endtask

  task automatic test_reset_midbusy();
    next_cycle();
    m1_valid = 1; m1_addr = 32'h80;
    settle();
    next_cycle(); settle();
    n_cmp++; if ({s_valid, s_addr} !== {1'b1, 32'h80}) begin n_bad++; $display("FAIL mid_busy got %b/%h want 1/00000080", s_valid, s_addr); end
    s_ready = 1;
    resetn = 1'b0;
    settle();
    n_cmp++; if ({s_valid, m0_ready, m1_ready} !== 3'b000) begin n_bad++; $display("FAIL mid_abort got %b want 000", {s_valid, m0_ready, m1_ready}); end
    next_cycle();
    next_cycle();
    s_ready = 0; resetn = 1'b1;
    m0_valid = 1; m0_addr = 32'h1234;
    settle();
    next_cycle(); settle();
    n_cmp++; if ({s_valid, s_addr} !== {1'b1, 32'h1234}) begin n_bad++; $display("FAIL mid_regrant got %b/%h want 1/00001234", s_valid, s_addr); end
    s_ready = 1; s_rdata = 32'h7;
    settle();
    n_cmp++; if ({m0_ready, m1_ready} !== 2'b10) begin n_bad++; $display("FAIL mid_regrant_ready got %b want 10", {m0_ready, m1_ready}); end
    next_cycle();
    idle_inputs();
    settle();
  endtask

  // Reference: both masters request continuously, so service must alternate
  // starting with master 0 after reset; each transfer occupies one idle cycle
  // plus (slave latency + 1) busy cycles.
  task automatic run_alternating(input int n, input int maxlat);
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [3:0]  st [2];
    logic [31:0] rd;
    int          winner;
    int          lat;
    logic [1:0]  exp_rdy;
    test_reset();
    for (int i = 0; i < 2; i++) begin
      a[i] = $urandom; d[i] = $urandom; st[i] = 4'($urandom_range(0, 15));
    end
    next_cycle();
    m0_valid = 1; m0_addr = a[0]; m0_wdata = d[0]; m0_wstrb = st[0];
    m1_valid = 1; m1_addr = a[1]; m1_wdata = d[1]; m1_wstrb = st[1];
    settle();
    winner = 0;
    for (int k = 0; k < n; k++) begin
      lat = $urandom_range(0, maxlat);
      rd  = $urandom;
      for (int w = 0; w <= lat; w++) begin
        next_cycle();
        s_ready = (w == lat); s_rdata = rd;
        settle();
        n_cmp++; if ({s_valid, s_addr, s_wdata, s_wstrb} !== {1'b1, a[winner], d[winner], st[winner]}) begin n_bad++; $display("FAIL alt_req xfer %0d got %b/%h/%h/%h want 1/%h/%h/%h", k, s_valid, s_addr, s_wdata, s_wstrb, a[winner], d[winner], st[winner]); end
        exp_rdy = (w == lat) ? ((winner == 0) ? 2'b10 : 2'b01) : 2'b00;
        n_cmp++; if ({m0_ready, m1_ready} !== exp_rdy) begin n_bad++; $display("FAIL alt_ready xfer %0d got %b want %b", k, {m0_ready, m1_ready}, exp_rdy); end
        if (w == lat) begin
          n_cmp++; if (((winner == 0) ? m0_rdata : m1_rdata) !== rd) begin n_bad++; $display("FAIL alt_rdata xfer %0d got %h want %h", k, (winner == 0) ? m0_rdata : m1_rdata, rd); end
        end
      end
      next_cycle();
      s_ready = 0;
      a[winner] = $urandom; d[winner] = $urandom; st[winner] = 4'($urandom_range(0, 15));
      if (winner == 0) begin m0_addr = a[0]; m0_wdata = d[0]; m0_wstrb = st[0]; end
      else             begin m1_addr = a[1]; m1_wdata = d[1]; m1_wstrb = st[1]; end
      settle();
      n_cmp++; if ({s_valid, m0_ready, m1_ready} !== 3'b000) begin n_bad++; $display("FAIL alt_bubble xfer %0d got %b want 000", k, {s_valid, m0_ready, m1_ready}); end
      winner = 1 - winner;
    end
    next_cycle();
    m0_valid = 0; m1_valid = 0;
    next_cycle();
    idle_inputs();
    settle();
  endtask

  task automatic test_back_to_back();
    run_alternating(6, 0);
  endtask

  task automatic test_random_latency();
    run_alternating(24, 3);
  endtask

  initial begin
    idle_inputs();
    #1;
    test_reset();
    test_m0_read();
    test_m1_write();
    test_timeout();
    test_late_ready();
    test_reset_midbusy();
    test_back_to_back();
    test_random_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
